// File: rtl/stream_answer_checker.sv
// stream_answer_checker
// Captures a non-back-pressurable "actual" byte stream into a FIFO and compares
// it, in order, against a ready/valid "expected" stream. Reports pass/fail,
// match/error counts and details of the first compare error. Optional CR/LF
// equivalence treats 0x0A and 0x0D as the same character on either side.
module stream_answer_checker #(
    parameter int DW       = 8,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 16,
    parameter int NORM_EOL = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             ACT_VALID,
    input  logic [DW-1:0]    ACT_DATA,
    input  logic             EXP_VALID,
    input  logic [DW-1:0]    EXP_DATA,
    input  logic             EXP_LAST,
    output logic             EXP_READY,
    output logic             DONE,
    output logic             PASS,
    output logic [CNT_W-1:0] MATCH_CNT,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [CNT_W-1:0] FIRST_ERR_IDX,
    output logic [DW-1:0]    FIRST_ERR_EXP,
    output logic [DW-1:0]    FIRST_ERR_ACT,
    output logic             OVERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0]    PTR_ZERO = {(AW+1){1'b0}};
    localparam logic [DW-1:0]  LF_C     = DW'(8'h0A);
    localparam logic [DW-1:0]  CR_C     = DW'(8'h0D);
    localparam logic [DW-1:0]  DATA_ZERO = {DW{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Line-ending bytes are interchangeable only for byte-wide streams.
    function automatic logic is_eol(input logic [DW-1:0] v);
        is_eol = (v == LF_C) || (v == CR_C);
    endfunction

    function automatic logic data_eq(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (a == b) begin
            data_eq = 1'b1;
        end else if ((NORM_EOL != 0) && (DW == 8)) begin
            data_eq = is_eol(a) && is_eol(b);
        end else begin
            data_eq = 1'b0;
        end
    endfunction

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1'b1);
        end
    endfunction

    state_t            state_r, state_nx_s;
    logic [DW-1:0]     mem_r [DEPTH];
    logic [AW:0]       wr_ptr_r, rd_ptr_r;
    logic              act_seen_r, act_end_r, exp_end_r;
    logic [CNT_W-1:0]  cmp_idx_r, match_cnt_r, err_cnt_r;
    logic              first_err_seen_r;
    logic [CNT_W-1:0]  first_err_idx_r;
    logic [DW-1:0]     first_err_exp_r, first_err_act_r;
    logic              overflow_r, done_r, pass_r;

    logic              run_s, empty_s, full_s, exp_ready_s, hs_s, extra_s;
    logic              pop_s, act_req_s, push_s, drop_s;
    logic [AW:0]       count_s, count_nx_s;
    logic [DW-1:0]     head_s;
    logic              cmp_ok_s, cmp_err_s;
    logic [DW-1:0]     err_exp_s, err_act_s;
    logic              act_seen_nx_s, act_end_nx_s, exp_end_nx_s, overflow_nx_s;
    logic [CNT_W-1:0]  cmp_idx_nx_s, match_cnt_nx_s, err_cnt_nx_s;
    logic              enter_done_s, done_nx_s, pass_nx_s;

    // FIFO status, handshake and push/pop/drop decisions for this cycle.
    always_comb begin
        run_s       = (state_r == ST_RUN);
        count_s     = wr_ptr_r - rd_ptr_r;
        empty_s     = (count_s == PTR_ZERO);
        full_s      = (count_s == FULL_C);
        head_s      = mem_r[rd_ptr_r[AW-1:0]];
        exp_ready_s = run_s && !exp_end_r && (!empty_s || act_end_r);
        hs_s        = EXP_VALID && exp_ready_s;
        // Once the expected stream has ended, leftovers drain one per cycle.
        extra_s     = run_s && exp_end_r && !empty_s;
        pop_s       = (hs_s && !empty_s) || extra_s;
        act_req_s   = run_s && ACT_VALID && !act_end_r;
        // A full FIFO still accepts a byte when a pop frees a slot this cycle.
        push_s      = act_req_s && (!full_s || pop_s);
        drop_s      = act_req_s && full_s && !pop_s;
        count_nx_s  = count_s + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    end

    // Classify this cycle's compare event and the values a first error would record.
    always_comb begin
        cmp_ok_s  = 1'b0;
        cmp_err_s = 1'b0;
        err_exp_s = DATA_ZERO;
        err_act_s = DATA_ZERO;
        if (hs_s) begin
            if (empty_s) begin
                // Expected byte with no actual byte left: missing.
                cmp_err_s = 1'b1;
                err_exp_s = EXP_DATA;
            end else if (data_eq(EXP_DATA, head_s)) begin
                cmp_ok_s  = 1'b1;
            end else begin
                cmp_err_s = 1'b1;
                err_exp_s = EXP_DATA;
                err_act_s = head_s;
            end
        end else if (extra_s) begin
            // Actual byte beyond the end of the expected stream: extra.
            cmp_err_s = 1'b1;
            err_act_s = head_s;
        end else begin
            cmp_ok_s  = 1'b0;
        end
    end

    // Next values of stream-end flags, counters and the result registers.
    always_comb begin
        act_seen_nx_s  = act_seen_r || act_req_s;
        act_end_nx_s   = act_end_r || (run_s && act_seen_r && !ACT_VALID);
        exp_end_nx_s   = exp_end_r || (hs_s && EXP_LAST);
        overflow_nx_s  = overflow_r || drop_s;
        cmp_idx_nx_s   = (hs_s || extra_s) ? sat_inc(cmp_idx_r) : cmp_idx_r;
        match_cnt_nx_s = cmp_ok_s ? sat_inc(match_cnt_r) : match_cnt_r;
        // At most one error event per cycle: a drop needs a full FIFO and no pop.
        err_cnt_nx_s   = (cmp_err_s || drop_s) ? sat_inc(err_cnt_r) : err_cnt_r;
        enter_done_s   = run_s && (state_nx_s == ST_DONE);
        done_nx_s      = done_r || enter_done_s;
        if (enter_done_s) begin
            pass_nx_s = (err_cnt_nx_s == CNT_ZERO) && !overflow_nx_s;
        end else begin
            pass_nx_s = pass_r;
        end
    end

    // Next-state logic: finish in the same cycle the last pop/compare happens.
    always_comb begin
        state_nx_s = state_r;
        if (START) begin
            state_nx_s = ST_RUN;
        end else begin
            case (state_r)
                ST_IDLE: state_nx_s = ST_IDLE;
                ST_RUN: begin
                    if (act_end_nx_s && exp_end_nx_s && (count_nx_s == PTR_ZERO)) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end
                ST_DONE: state_nx_s = ST_DONE;
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= ACT_DATA;
        end
    end

    // State, pointers, flags and result registers; START restarts a clean check.
    always_ff @(posedge CLK) begin
        if (RESET || START) begin
            state_r          <= RESET ? ST_IDLE : ST_RUN;
            wr_ptr_r         <= PTR_ZERO;
            rd_ptr_r         <= PTR_ZERO;
            act_seen_r       <= 1'b0;
            act_end_r        <= 1'b0;
            exp_end_r        <= 1'b0;
            cmp_idx_r        <= CNT_ZERO;
            match_cnt_r      <= CNT_ZERO;
            err_cnt_r        <= CNT_ZERO;
            first_err_seen_r <= 1'b0;
            first_err_idx_r  <= CNT_ZERO;
            first_err_exp_r  <= DATA_ZERO;
            first_err_act_r  <= DATA_ZERO;
            overflow_r       <= 1'b0;
            done_r           <= 1'b0;
            pass_r           <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            wr_ptr_r    <= push_s ? (wr_ptr_r + (AW+1)'(1'b1)) : wr_ptr_r;
            rd_ptr_r    <= pop_s  ? (rd_ptr_r + (AW+1)'(1'b1)) : rd_ptr_r;
            act_seen_r  <= act_seen_nx_s;
            act_end_r   <= act_end_nx_s;
            exp_end_r   <= exp_end_nx_s;
            cmp_idx_r   <= cmp_idx_nx_s;
            match_cnt_r <= match_cnt_nx_s;
            err_cnt_r   <= err_cnt_nx_s;
            overflow_r  <= overflow_nx_s;
            done_r      <= done_nx_s;
            pass_r      <= pass_nx_s;
            // Only compare errors (not drops) record the first-error details.
            if (cmp_err_s && !first_err_seen_r) begin
                first_err_seen_r <= 1'b1;
                first_err_idx_r  <= cmp_idx_r;
                first_err_exp_r  <= err_exp_s;
                first_err_act_r  <= err_act_s;
            end
        end
    end

    assign EXP_READY     = exp_ready_s;
    assign DONE          = done_r;
    assign PASS          = pass_r;
    assign MATCH_CNT     = match_cnt_r;
    assign ERR_CNT       = err_cnt_r;
    assign FIRST_ERR_IDX = first_err_idx_r;
    assign FIRST_ERR_EXP = first_err_exp_r;
    assign FIRST_ERR_ACT = first_err_act_r;
    assign OVERFLOW      = overflow_r;

endmodule

// File: tb/tb_stream_answer_checker.sv
// tb_stream_answer_checker
// Directed and randomized checks of stream_answer_checker against a
// list-level reference model of the compare rules.
module tb_stream_answer_checker;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             RESET, START, ACT_VALID, EXP_VALID, EXP_LAST;
    logic [DW-1:0]    ACT_DATA, EXP_DATA;
    logic             EXP_READY, DONE, PASS, OVERFLOW;
    logic [CNT_W-1:0] MATCH_CNT, ERR_CNT, FIRST_ERR_IDX;
    logic [DW-1:0]    FIRST_ERR_EXP, FIRST_ERR_ACT;

    stream_answer_checker #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W), .NORM_EOL(1)) dut (
        .CLK(CLK), .RESET(RESET), .START(START),
        .ACT_VALID(ACT_VALID), .ACT_DATA(ACT_DATA),
        .EXP_VALID(EXP_VALID), .EXP_DATA(EXP_DATA), .EXP_LAST(EXP_LAST),
        .EXP_READY(EXP_READY), .DONE(DONE), .PASS(PASS),
        .MATCH_CNT(MATCH_CNT), .ERR_CNT(ERR_CNT), .FIRST_ERR_IDX(FIRST_ERR_IDX),
        .FIRST_ERR_EXP(FIRST_ERR_EXP), .FIRST_ERR_ACT(FIRST_ERR_ACT),
        .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errs   = 0;
    logic [7:0] act_q[$];
    logic [7:0] exp_q[$];
    logic act_done_f;
    logic done_at_last;
    int   m_match, m_err, m_idx;
    logic [7:0] m_fexp, m_fact;
    logic m_ovf, m_pass;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errs++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic same_char(input logic [7:0] a, input logic [7:0] b);
        return (a == b) || ((a == 8'h0A || a == 8'h0D) && (b == 8'h0A || b == 8'h0D));
    endfunction

    // Reference: pair the i-th kept actual byte with the i-th expected byte.
    task automatic model(input int drops);
        int na, ne, len;
        logic seen;
        na = act_q.size() - drops;
        ne = exp_q.size();
        len = (na > ne) ? na : ne;
        m_match = 0; m_err = 0; m_idx = 0; m_fexp = 8'h00; m_fact = 8'h00; seen = 1'b0;
        for (int i = 0; i < len; i++) begin
            logic bad;
            logic [7:0] ev, av;
            ev = (i < ne) ? exp_q[i] : 8'h00;
            av = (i < na) ? act_q[i] : 8'h00;
            bad = !((i < ne) && (i < na) && same_char(ev, av));
            if (bad) begin
                m_err++;
                if (!seen) begin
                    seen = 1'b1; m_idx = i; m_fexp = ev; m_fact = av;
                end
            end else begin
                m_match++;
            end
        end
        m_err  = m_err + drops;
        m_ovf  = (drops > 0);
        m_pass = (m_err == 0) && !m_ovf;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_act();
        foreach (act_q[i]) begin
            ACT_VALID = 1'b1;
            ACT_DATA  = act_q[i];
            tick();
        end
        ACT_VALID  = 1'b0;
        act_done_f = 1'b1;
    endtask

    // mode 0: always valid, 1: toggling, 2: random, 3: held off until actual ends
    task automatic drive_exp(input int mode);
        int i = 0;
        int guard = 0;
        logic tog = 1'b1;
        logic v, hs;
        while (i < exp_q.size() && guard < 2000) begin
            case (mode)
                0: v = 1'b1;
                1: v = tog;
                2: v = 1'($urandom_range(0, 1));
                default: v = act_done_f;
            endcase
            tog = ~tog;
            EXP_VALID = v;
            EXP_DATA  = exp_q[i];
            EXP_LAST  = (i == exp_q.size() - 1);
            @(negedge CLK);
            hs = v && EXP_READY;
            tick();
            if (hs) begin
                i++;
                if (i == exp_q.size()) done_at_last = DONE;
            end
            guard++;
        end
        EXP_VALID = 1'b0;
        EXP_LAST  = 1'b0;
        chk("exp_stream_timeout", 32'(guard < 2000), 32'(1));
    endtask

    task automatic run_check(input string name, input int mode, input int drops);
        int w = 0;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk({name, "_start_done"}, 32'(DONE), 32'(0));
        chk({name, "_start_err"}, 32'(ERR_CNT), 32'(0));
        chk({name, "_start_ovf"}, 32'(OVERFLOW), 32'(0));
        act_done_f = 1'b0;
        done_at_last = 1'b0;
        fork
            drive_act();
            drive_exp(mode);
        join
        while (DONE !== 1'b1 && w < 300) begin
            tick();
            w++;
        end
        model(drops);
        chk({name, "_done"}, 32'(DONE), 32'(1));
        chk({name, "_pass"}, 32'(PASS), 32'(m_pass));
        chk({name, "_match"}, 32'(MATCH_CNT), 32'(m_match));
        chk({name, "_err"}, 32'(ERR_CNT), 32'(m_err));
        chk({name, "_fidx"}, 32'(FIRST_ERR_IDX), 32'(m_idx));
        chk({name, "_fexp"}, 32'(FIRST_ERR_EXP), 32'(m_fexp));
        chk({name, "_fact"}, 32'(FIRST_ERR_ACT), 32'(m_fact));
        chk({name, "_ovf"}, 32'(OVERFLOW), 32'(m_ovf));
        chk({name, "_ready_off"}, 32'(EXP_READY), 32'(0));
    endtask

    function automatic logic [7:0] rand_char();
        case ($urandom_range(0, 3))
            0: return 8'h0A;
            1: return 8'h0D;
            2: return 8'h41 + 8'($urandom_range(0, 2));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic check_all_zero(input string name);
        chk({name, "_done"}, 32'(DONE), 32'(0));
        chk({name, "_pass"}, 32'(PASS), 32'(0));
        chk({name, "_match"}, 32'(MATCH_CNT), 32'(0));
        chk({name, "_err"}, 32'(ERR_CNT), 32'(0));
        chk({name, "_fidx"}, 32'(FIRST_ERR_IDX), 32'(0));
        chk({name, "_fexp"}, 32'(FIRST_ERR_EXP), 32'(0));
        chk({name, "_fact"}, 32'(FIRST_ERR_ACT), 32'(0));
        chk({name, "_ovf"}, 32'(OVERFLOW), 32'(0));
        chk({name, "_ready"}, 32'(EXP_READY), 32'(0));
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; ACT_VALID = 1'b0; ACT_DATA = 8'h00;
        EXP_VALID = 1'b0; EXP_DATA = 8'h00; EXP_LAST = 1'b0;
        act_done_f = 1'b0; done_at_last = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
        check_all_zero("reset");

        // "Yes\r" against "Yes\n": line endings are equivalent.
        act_q = '{8'h59, 8'h65, 8'h73, 8'h0D};
        exp_q = '{8'h59, 8'h65, 8'h73, 8'h0A};
        run_check("exact", 0, 0);

        // "No" against "Oo": a single mismatch in the first position.
        act_q = '{8'h4E, 8'h6F};
        exp_q = '{8'h4F, 8'h6F};
        run_check("mismatch", 0, 0);

        // Outputs stay frozen in DONE while the actual side keeps toggling.
        ACT_VALID = 1'b1; ACT_DATA = 8'h55; EXP_VALID = 1'b1;
        tick(); tick(); tick();
        ACT_VALID = 1'b0; EXP_VALID = 1'b0;
        chk("frozen_err", 32'(ERR_CNT), 32'(m_err));
        chk("frozen_match", 32'(MATCH_CNT), 32'(m_match));
        chk("frozen_done", 32'(DONE), 32'(1));

        // Short actual: two missing bytes.
        act_q = '{8'h31, 8'h32, 8'h33};
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        run_check("short_act", 0, 0);

        // Long actual: two extra bytes.
        act_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        exp_q = '{8'h31, 8'h32, 8'h33};
        run_check("long_act", 0, 0);

        // 20 bytes with no pops until the actual stream ends: 4 drops.
        act_q.delete();
        for (int i = 0; i < 20; i++) act_q.push_back(8'(8'h40 + i));
        exp_q = act_q;
        run_check("overflow", 3, 20 - DEPTH);

        // Toggled expected valid: completion the cycle after the last handshake.
        act_q.delete();
        for (int i = 0; i < 10; i++) act_q.push_back(8'(8'h61 + i));
        exp_q = act_q;
        run_check("backpressure", 1, 0);
        chk("backpressure_done_latency", 32'(done_at_last), 32'(1));

        // Randomized streams, never longer than the FIFO so nothing drops.
        for (int t = 0; t < 8; t++) begin
            int na, ne;
            na = $urandom_range(1, DEPTH);
            ne = na + int'($urandom_range(0, 4)) - 2;
            if (ne < 1) ne = 1;
            act_q.delete();
            exp_q.delete();
            for (int i = 0; i < na; i++) act_q.push_back(rand_char());
            for (int i = 0; i < ne; i++) begin
                if (i < na && $urandom_range(0, 5) != 0) exp_q.push_back(act_q[i]);
                else exp_q.push_back(rand_char());
            end
            run_check($sformatf("rand%0d", t), int'($urandom_range(0, 2)), 0);
        end

        // Reset in the middle of a check with an error already recorded.
        START = 1'b1; tick(); START = 1'b0;
        ACT_VALID = 1'b1; ACT_DATA = 8'h11; tick();
        ACT_DATA = 8'h22; tick();
        ACT_VALID = 1'b0;
        EXP_VALID = 1'b1; EXP_DATA = 8'h33; EXP_LAST = 1'b0; tick();
        EXP_VALID = 1'b0;
        chk("midrun_err", 32'(ERR_CNT), 32'(1));
        chk("midrun_fact", 32'(FIRST_ERR_ACT), 32'(8'h11));
        RESET = 1'b1; tick(); RESET = 1'b0;
        check_all_zero("midrun_reset");
        ACT_VALID = 1'b1; ACT_DATA = 8'h44; tick(); ACT_VALID = 1'b0;
        chk("idle_ignores_act", 32'(EXP_READY), 32'(0));

        // START together with RESET: reset wins and the checker stays idle.
        START = 1'b1; RESET = 1'b1; tick(); START = 1'b0; RESET = 1'b0;
        ACT_VALID = 1'b1; ACT_DATA = 8'h45; tick(); ACT_VALID = 1'b0;
        chk("start_reset_idle", 32'(EXP_READY), 32'(0));

        // A fresh check after the aborted one is independent of it.
        act_q = '{8'h0D, 8'h41};
        exp_q = '{8'h0A, 8'h41};
        run_check("after_reset", 2, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
